// File: rtl/regfile_pkg.sv
// Shared constants and types for the LC-3 register file and its write-port arbitration.
package regfile_pkg;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned NREG   = 8;
    localparam int unsigned REG_AW = $clog2(NREG);

    typedef enum logic {ARB, CLEAR} wr_arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: one-hot grant to the first request at or above
// i_ptr, wrapping from N-1 to 0.
module rr_pick #(
    parameter int unsigned N     = 3,
    parameter int unsigned PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_gnt
);

    logic             w_found;
    logic [PTR_W-1:0] w_idx;

    always_comb begin
        o_gnt   = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 0; k < int'(N); k++) begin
            w_idx = PTR_W'((int'(i_ptr) + k) % int'(N));
            if (!w_found && i_req[w_idx]) begin
                o_gnt[w_idx] = 1'b1;
                w_found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbitration of the register-file write port among NREQ requesters, plus a
// hardware clear sequence that zeroes every register. All register-file outputs are registered.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned NREQ = 3
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic [NREQ-1:0]        Req_Valid,
    input  logic [NREQ*REG_AW-1:0] Req_DR,
    input  logic [NREQ*DATA_W-1:0] Req_Data,
    output logic [NREQ-1:0]        Req_Ready,
    input  logic                   Clear_Start,
    output logic                   Clear_Busy,
    output logic                   Ld_REG,
    output logic [REG_AW-1:0]      DRMUX,
    output logic [DATA_W-1:0]      In
);

    localparam int unsigned PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

    wr_arb_state_t     r_state;
    logic [PTR_W-1:0]  r_rr_ptr;
    logic [REG_AW-1:0] r_clr_cnt;
    logic              r_ld;
    logic [REG_AW-1:0] r_drmux;
    logic [DATA_W-1:0] r_in;
    logic              r_busy;

    logic [NREQ-1:0]   w_gnt;
    logic [NREQ-1:0]   w_ready;
    logic              w_xfer;
    logic [PTR_W-1:0]  w_gidx;
    logic [PTR_W-1:0]  w_next_ptr;
    logic [REG_AW-1:0] w_dr;
    logic [DATA_W-1:0] w_data;

    rr_pick #(
        .N     (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .i_req (Req_Valid),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt)
    );

    // Clear_Start wins over requests, and nothing is granted while Reset is held.
    assign w_ready   = (r_state == ARB && !Clear_Start && !Reset) ? w_gnt : '0;
    assign Req_Ready = w_ready;
    assign w_xfer    = |(w_ready & Req_Valid);

    always_comb begin
        w_gidx = '0;
        w_dr   = '0;
        w_data = '0;
        for (int i = 0; i < int'(NREQ); i++) begin
            if (w_ready[i]) begin
                w_gidx = PTR_W'(i);
                w_dr   = Req_DR[i*REG_AW +: REG_AW];
                w_data = Req_Data[i*DATA_W +: DATA_W];
            end
        end
    end

    assign w_next_ptr = (w_gidx == PTR_W'(NREQ - 1)) ? '0 : w_gidx + 1'b1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state   <= ARB;
            r_rr_ptr  <= '0;
            r_clr_cnt <= '0;
            r_ld      <= 1'b0;
            r_drmux   <= '0;
            r_in      <= '0;
            r_busy    <= 1'b0;
        end else begin
            case (r_state)
                ARB: begin
                    if (Clear_Start) begin
                        r_state   <= CLEAR;
                        r_clr_cnt <= '0;
                        r_busy    <= 1'b1;
                        r_ld      <= 1'b0;
                    end else if (w_xfer) begin
                        r_ld     <= 1'b1;
                        r_drmux  <= w_dr;
                        r_in     <= w_data;
                        r_rr_ptr <= w_next_ptr;
                    end else begin
                        r_ld <= 1'b0;
                    end
                end
                CLEAR: begin
                    r_ld      <= 1'b1;
                    r_drmux   <= r_clr_cnt;
                    r_in      <= '0;
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == REG_AW'(NREG - 1)) begin
                        r_state <= ARB;
                        r_busy  <= 1'b0;
                    end
                end
                default: r_state <= ARB;
            endcase
        end
    end

    assign Ld_REG     = r_ld;
    assign DRMUX      = r_drmux;
    assign In         = r_in;
    assign Clear_Busy = r_busy;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, hand-written clear/reset/overlap
// sequences, then randomized traffic against a behavioural model with a register-file image.
module tb_regfile_write_arbiter;

    localparam int NREQ = 3;
    localparam int RAW  = 3;
    localparam int DW   = 16;

    logic              Clk = 1'b0;
    logic              Reset;
    logic [NREQ-1:0]   Req_Valid;
    logic [NREQ*RAW-1:0] Req_DR;
    logic [NREQ*DW-1:0]  Req_Data;
    logic [NREQ-1:0]   Req_Ready;
    logic              Clear_Start;
    logic              Clear_Busy;
    logic              Ld_REG;
    logic [RAW-1:0]    DRMUX;
    logic [DW-1:0]     In;

    regfile_write_arbiter #(.NREQ(NREQ)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .Req_Valid   (Req_Valid),
        .Req_DR      (Req_DR),
        .Req_Data    (Req_Data),
        .Req_Ready   (Req_Ready),
        .Clear_Start (Clear_Start),
        .Clear_Busy  (Clear_Busy),
        .Ld_REG      (Ld_REG),
        .DRMUX       (DRMUX),
        .In          (In)
    );

    always #5 Clk = ~Clk;

    // Register file image driven by the arbiter outputs.
    logic [DW-1:0] rf [8];
    always @(posedge Clk) if (Ld_REG) rf[DRMUX] <= In;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    typedef struct {
        logic        rst;
        logic [2:0]  valid;
        logic [2:0]  ready;
        logic        ld;
        logic [2:0]  dr;
        logic [15:0] din;
    } vec_t;

    vec_t vecs[14];

    // Random-phase model state
    int            m_ptr;
    bit            m_clear;
    int            m_cnt;
    bit            m_ld;
    int            m_dr;
    logic [15:0]   m_in;
    logic [15:0]   exp_rf [8];
    bit            m_wr [8];
    logic [2:0]    cv;
    logic [2:0]    cdr [3];
    logic [15:0]   cdt [3];

    initial begin
        Reset       = 1'b1;
        Req_Valid   = '0;
        Req_DR      = '0;
        Req_Data    = '0;
        Clear_Start = 1'b0;
        tick();
        tick();

        // ---- table: single write, hold, reset, 0/1/2 rotation, wrap search ----
        vecs[0]  = '{1'b1, 3'b000, 3'b000, 1'b0, 3'd0, 16'h0000};
        vecs[1]  = '{1'b0, 3'b001, 3'b001, 1'b1, 3'd3, 16'hBEEF};
        vecs[2]  = '{1'b0, 3'b000, 3'b000, 1'b0, 3'd3, 16'hBEEF};
        vecs[3]  = '{1'b1, 3'b111, 3'b000, 1'b0, 3'd0, 16'h0000};
        vecs[4]  = '{1'b0, 3'b111, 3'b001, 1'b1, 3'd3, 16'hBEEF};
        vecs[5]  = '{1'b0, 3'b111, 3'b010, 1'b1, 3'd1, 16'h1111};
        vecs[6]  = '{1'b0, 3'b111, 3'b100, 1'b1, 3'd6, 16'h2222};
        vecs[7]  = '{1'b0, 3'b111, 3'b001, 1'b1, 3'd3, 16'hBEEF};
        vecs[8]  = '{1'b0, 3'b111, 3'b010, 1'b1, 3'd1, 16'h1111};
        vecs[9]  = '{1'b0, 3'b111, 3'b100, 1'b1, 3'd6, 16'h2222};
        vecs[10] = '{1'b0, 3'b000, 3'b000, 1'b0, 3'd6, 16'h2222};
        vecs[11] = '{1'b0, 3'b010, 3'b010, 1'b1, 3'd1, 16'h1111};
        vecs[12] = '{1'b0, 3'b011, 3'b001, 1'b1, 3'd3, 16'hBEEF};
        vecs[13] = '{1'b0, 3'b000, 3'b000, 1'b0, 3'd3, 16'hBEEF};

        Req_DR   = {3'd6, 3'd1, 3'd3};
        Req_Data = {16'h2222, 16'h1111, 16'hBEEF};
        for (int i = 0; i < 14; i++) begin
            Reset     = vecs[i].rst;
            Req_Valid = vecs[i].valid;
            @(negedge Clk);
            chk($sformatf("vec%0d ready", i), 32'(Req_Ready), 32'(vecs[i].ready));
            tick();
            chk($sformatf("vec%0d ld", i), 32'(Ld_REG), 32'(vecs[i].ld));
            chk($sformatf("vec%0d drmux", i), 32'(DRMUX), 32'(vecs[i].dr));
            chk($sformatf("vec%0d in", i), 32'(In), 32'(vecs[i].din));
        end
        Reset = 1'b0;

        // ---- clear with simultaneous requests, re-trigger mid-clear ignored (rr_ptr=1) ----
        Req_Valid   = 3'b011;
        Clear_Start = 1'b1;
        @(negedge Clk);
        chk("clr start ready", 32'(Req_Ready), 32'd0);
        tick();
        chk("clr start busy", 32'(Clear_Busy), 32'd1);
        chk("clr start ld", 32'(Ld_REG), 32'd0);
        for (int k = 0; k < 8; k++) begin
            Clear_Start = (k == 2);
            @(negedge Clk);
            chk($sformatf("clr%0d ready", k), 32'(Req_Ready), 32'd0);
            tick();
            chk($sformatf("clr%0d ld", k), 32'(Ld_REG), 32'd1);
            chk($sformatf("clr%0d drmux", k), 32'(DRMUX), 32'(k));
            chk($sformatf("clr%0d in", k), 32'(In), 32'd0);
            chk($sformatf("clr%0d busy", k), 32'(Clear_Busy), (k < 7) ? 32'd1 : 32'd0);
        end
        Clear_Start = 1'b0;
        @(negedge Clk);
        chk("post clr ready", 32'(Req_Ready), 32'b010);
        tick();
        chk("post clr in", 32'(In), 32'h1111);
        for (int r = 0; r < 8; r++) chk($sformatf("clr rf%0d", r), 32'(rf[r]), 32'd0);
        Req_Valid = '0;
        tick();

        // ---- load known values, then reset during the 4th clear cycle ----
        for (int r = 0; r < 8; r++) begin
            Req_Valid          = 3'b001;
            Req_DR[2:0]        = 3'(r);
            Req_Data[15:0]     = 16'h1000 + 16'(r);
            tick();
        end
        Req_Valid = '0;
        tick();
        tick();
        for (int r = 0; r < 8; r++) chk($sformatf("load rf%0d", r), 32'(rf[r]), 32'h1000 + r);
        Clear_Start = 1'b1;
        tick();
        Clear_Start = 1'b0;
        tick();
        tick();
        tick();
        Reset = 1'b1;
        tick();
        chk("rst ld", 32'(Ld_REG), 32'd0);
        chk("rst busy", 32'(Clear_Busy), 32'd0);
        chk("rst drmux", 32'(DRMUX), 32'd0);
        Reset = 1'b0;
        tick();
        tick();
        for (int r = 0; r < 3; r++) chk($sformatf("abort rf%0d", r), 32'(rf[r]), 32'd0);
        for (int r = 4; r < 8; r++) chk($sformatf("keep rf%0d", r), 32'(rf[r]), 32'h1000 + r);

        // ---- same-DR overlap with rr_ptr=1: requester 2 then 0, last write wins ----
        Req_Valid      = 3'b001;
        Req_DR[2:0]    = 3'd0;
        Req_Data[15:0] = 16'h1234;
        tick();
        Req_Valid       = 3'b101;
        Req_DR[2:0]     = 3'd5;
        Req_DR[8:6]     = 3'd5;
        Req_Data[15:0]  = 16'hAAAA;
        Req_Data[47:32] = 16'h5555;
        @(negedge Clk);
        chk("ovl ready1", 32'(Req_Ready), 32'b100);
        tick();
        chk("ovl in1", 32'(In), 32'h5555);
        chk("ovl dr1", 32'(DRMUX), 32'd5);
        Req_Valid = 3'b001;
        @(negedge Clk);
        chk("ovl ready2", 32'(Req_Ready), 32'b001);
        tick();
        chk("ovl in2", 32'(In), 32'hAAAA);
        Req_Valid = '0;
        tick();
        tick();
        chk("ovl rf5", 32'(rf[5]), 32'hAAAA);

        // ---- randomized traffic against the behavioural model ----
        Reset = 1'b1;
        tick();
        Reset   = 1'b0;
        m_ptr   = 0;
        m_clear = 0;
        m_cnt   = 0;
        m_ld    = 0;
        m_dr    = 0;
        m_in    = '0;
        cv      = '0;
        for (int r = 0; r < 8; r++) m_wr[r] = 0;
        for (int i = 0; i < 3; i++) begin
            cdr[i] = '0;
            cdt[i] = '0;
        end
        for (int cyc = 0; cyc < 620; cyc++) begin
            int g;
            logic [2:0] er;
            bit quiet;
            quiet = (cyc >= 600);
            for (int i = 0; i < 3; i++) begin
                if (!cv[i] && !quiet && ($urandom % 2 == 0)) begin
                    cv[i]  = 1'b1;
                    cdr[i] = 3'($urandom % 8);
                    cdt[i] = 16'($urandom);
                end
            end
            Clear_Start = !quiet && ($urandom % 25 == 0);
            Req_Valid   = cv;
            for (int i = 0; i < 3; i++) begin
                Req_DR[i*RAW +: RAW]  = cdr[i];
                Req_Data[i*DW +: DW]  = cdt[i];
            end
            // Expected grant: first pending requester in rotation order from the pointer.
            g  = -1;
            er = '0;
            if (!m_clear && !Clear_Start) begin
                for (int k = 0; k < 3; k++) begin
                    if (g < 0 && cv[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
                end
                if (g >= 0) er[g] = 1'b1;
            end
            @(negedge Clk);
            chk("rnd ready", 32'(Req_Ready), 32'(er));
            if (m_clear) begin
                m_ld = 1;
                m_dr = m_cnt;
                m_in = '0;
                exp_rf[m_cnt] = '0;
                m_wr[m_cnt]   = 1;
                m_cnt++;
                if (m_cnt == 8) m_clear = 0;
            end else if (Clear_Start) begin
                m_clear = 1;
                m_cnt   = 0;
                m_ld    = 0;
            end else if (g >= 0) begin
                m_ld  = 1;
                m_dr  = int'(cdr[g]);
                m_in  = cdt[g];
                exp_rf[cdr[g]] = cdt[g];
                m_wr[cdr[g]]   = 1;
                m_ptr = (g + 1) % 3;
                cv[g] = 1'b0;
            end else begin
                m_ld = 0;
            end
            tick();
            chk("rnd ld", 32'(Ld_REG), 32'(m_ld));
            chk("rnd drmux", 32'(DRMUX), 32'(m_dr));
            chk("rnd in", 32'(In), 32'(m_in));
            chk("rnd busy", 32'(Clear_Busy), 32'(m_clear));
        end
        Clear_Start = 1'b0;
        Req_Valid   = '0;
        tick();
        for (int r = 0; r < 8; r++) begin
            if (m_wr[r]) chk($sformatf("rnd rf%0d", r), 32'(rf[r]), 32'(exp_rf[r]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
